// File: rtl/smi_master.sv
// -----------------------------------------------------------------------------
// smi_master: IEEE 802.3 Clause 22 station-management (MDC/MDIO) master.
// Takes one register command at a time. It serialises the command MSB first
// and returns read data with a one-cycle response pulse.
//
// Build option: SMI_PREAMBLE_EN
//   defined   - a 32-bit all-ones preamble is sent, so the frame is 64 bits.
//   undefined - the preamble is suppressed and the frame starts at ST. The
//               frame is 32 bits (numbered 32..63).
//
// Ports
//   CLK, rst            system clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_write           1 = write (OP 01), 0 = read (OP 10)
//   cmd_phy, cmd_reg    PHY / register address
//   cmd_wdata           write data
//   rsp_valid           one-cycle pulse at frame end
//   rsp_rdata, rsp_err  read data (0 after a write), TA error (reads only)
//   MDC                 management clock, CLK_DIV cycles per phase
//   MDIO_O/OE/I         MDIO pad signals; the tristate is built outside
// -----------------------------------------------------------------------------
module smi_master #(
  parameter int unsigned CLK_DIV = 32   // MDC half period in CLK cycles, 1..255
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I
);

`ifdef SMI_PREAMBLE_EN
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SHIFT, S_DONE} state_e;
  localparam state_e     START_ST  = S_PRE;
  localparam logic [5:0] FIRST_BIT = 6'd0;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  localparam state_e     START_ST  = S_SHIFT;
  localparam logic [5:0] FIRST_BIT = 6'd32;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [63:0] frame_q, frame_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic [15:0] shreg_q, shreg_d;
  logic        err_q, err_d;
  logic [1:0]  sync_q;

  logic        div_end;
  logic        is_rd;
  logic        mdio_s;
  logic [5:0]  bit_nx;
  logic [63:0] new_frame;

  // Frame bit n lives at frame_q[63-n], i.e. frame_q[~n] for a 6-bit n.
  assign new_frame = {32'hFFFF_FFFF, 2'b01,
                      cmd_write ? 2'b01 : 2'b10,
                      cmd_phy, cmd_reg,
                      cmd_write ? 2'b10 : 2'b11,
                      cmd_write ? cmd_wdata : 16'hFFFF};

  assign is_rd   = frame_q[29];            // first OP bit: 1 only for reads
  assign mdio_s  = sync_q[1];
  assign div_end = (div_q == DIV_LAST);
  assign bit_nx  = bit_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rerr_d      = rerr_q;
    shreg_d     = shreg_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = START_ST;
          frame_d = new_frame;
          bit_d   = FIRST_BIT;
          div_d   = 8'd0;
          mdc_d   = 1'b0;
          oe_d    = 1'b1;
          mdo_d   = new_frame[~FIRST_BIT];
        end
      end
`ifdef SMI_PREAMBLE_EN
      S_PRE,
`endif
      S_SHIFT: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          mdc_d = ~mdc_q;
          if (!mdc_q) begin
            // MDC rising at this edge: PHY data is sampled here.
            if (is_rd && bit_q == 6'd47)
              err_d = mdio_s;                  // PHY must drive TA low
            else if (is_rd && bit_q >= 6'd48)
              shreg_d = {shreg_q[14:0], mdio_s};
          end else if (bit_q == 6'd63) begin
            // Last falling edge: release the bus and report.
            state_d     = S_DONE;
            mdo_d       = 1'b1;
            oe_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rdata_d     = is_rd ? shreg_q : 16'h0000;
            rerr_d      = is_rd & err_q;
          end else begin
            // MDC falling: present the next bit with a full low phase of setup.
            bit_d = bit_nx;
            mdo_d = frame_q[~bit_nx];
            oe_d  = ~(is_rd && bit_nx >= 6'd46);
`ifdef SMI_PREAMBLE_EN
            if (state_q == S_PRE && bit_q == 6'd31) state_d = S_SHIFT;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered so that ready is low throughout reset and for one cycle after it.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 6'd0;
      frame_q     <= 64'd0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'h0000;
      rerr_q      <= 1'b0;
      shreg_q     <= 16'h0000;
      err_q       <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
      shreg_q     <= shreg_d;
      err_q       <= err_d;
      sync_q      <= {sync_q[0], MDIO_I};
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign MDC       = mdc_q;
  assign MDIO_O    = mdo_q;
  assign MDIO_OE   = oe_q;

endmodule

// File: tb/tb_smi_master.sv
`timescale 1ns/1ps
module tb_smi_master;
  localparam int D = 4;
`ifdef SMI_PREAMBLE_EN
  localparam int NBITS = 64;
  localparam int FIRST = 0;
`else
  localparam int NBITS = 32;
  localparam int FIRST = 32;
`endif
  localparam int LAT = 2 * D * NBITS + 1;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy = '0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        MDC, MDIO_O, MDIO_OE;
  logic        MDIO_I = 1'b1;

  smi_master #(.CLK_DIV(D)) dut (
    .CLK(CLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .MDC(MDC), .MDIO_O(MDIO_O), .MDIO_OE(MDIO_OE), .MDIO_I(MDIO_I)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic [63:0] frame;
    logic [63:0] mask;
    logic [63:0] oe;
  } exp_t;

  typedef struct {
    logic        w;
    logic [4:0]  p;
    logic [4:0]  r;
    logic [15:0] d;
    logic        pres;
    logic [15:0] pv;
    logic [15:0] xr;
    logic        xe;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[7];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cnt = 0;
  int mon_bit = -1;
  int mon_rises = 0;
  int nb;
  logic [63:0] mon_o = '1;
  logic [63:0] mon_oe = '1;
  logic mdc_prev = 1'b0;
  logic phy_present = 1'b0;
  logic [15:0] phy_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line monitor, PHY model and response scoreboard.
  always @(negedge CLK) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (!rst) begin
      mon_o = '1; mon_oe = '1; mon_rises = 0; mon_bit = -1;
      MDIO_I = 1'b1;
    end else if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
        chk("rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("err", 64'(rsp_err), 64'(e.err));
        chk("stream", mon_o & e.mask, e.frame & e.mask);
        chk("oe", mon_oe, e.oe);
        chk("nbits", 64'(mon_rises), 64'(NBITS));
      end
      mon_o = '1; mon_oe = '1; mon_rises = 0; mon_bit = -1;
      MDIO_I = 1'b1;
    end else if (!mdc_prev && MDC) begin
      mon_bit = FIRST + mon_rises;
      mon_rises++;
      if (mon_bit <= 63) begin
        mon_o[63 - mon_bit]  = MDIO_O;
        mon_oe[63 - mon_bit] = MDIO_OE;
      end
      // PHY drives the next bit after the rising edge, like a real PHY.
      nb = mon_bit + 1;
      if (mon_o[29:28] == 2'b10 && nb >= 47 && nb <= 63)
        MDIO_I = !phy_present ? 1'b1 : (nb == 47 ? 1'b0 : phy_val[63 - nb]);
      else
        MDIO_I = 1'b1;
    end
    mdc_prev = MDC;
  end

  task automatic push_exp(input logic w, input logic [4:0] p, input logic [4:0] r,
                          input logic [15:0] d, input logic [15:0] xr, input logic xe);
    exp_t x;
    x.rdata = xr;
    x.err   = xe;
    x.frame = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), p, r, 2'b10, d};
    x.mask  = w ? '1 : {{46{1'b1}}, 18'b0};
    x.oe    = w ? '1 : {{46{1'b1}}, 18'b0};
    sb.push_back(x);
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (cmd_valid && cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_rsp();
    int n0 = rsp_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (rsp_cnt != n0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic w, input logic [4:0] p, input logic [4:0] r,
                      input logic [15:0] d, input logic pres, input logic [15:0] pv,
                      input logic [15:0] xr, input logic xe, input bit push);
    phy_present = pres;
    phy_val     = pv;
    cmd_write = w; cmd_phy = p; cmd_reg = r; cmd_wdata = d;
    cmd_valid = 1'b1;
    if (push) push_exp(w, p, r, d, xr, xe);
    wait_accept();
    // Scramble the command fields mid-frame; the frame must not change.
    cmd_valid = 1'b0;
    cmd_write = ~w; cmd_phy = ~p; cmd_reg = ~r; cmd_wdata = ~d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, rc;
    bit ok;
    tbl[0] = '{1'b1, 5'd1,  5'd0,  16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd1,  5'd2,  16'h0000, 1'b1, 16'h7949, 16'h7949, 1'b0};
    tbl[2] = '{1'b1, 5'd21, 5'd10, 16'hA5A5, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 5'd1,  5'd3,  16'h1234, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b1, 5'd31, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 5'd0,  5'd0,  16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 5'd31, 5'd1,  16'h0000, 1'b1, 16'h8001, 16'h8001, 1'b0};

    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, MDC, MDIO_O, MDIO_OE},
        {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge CLK); #1;
    rst = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Table of single commands
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].w, tbl[i].p, tbl[i].r, tbl[i].d, tbl[i].pres, tbl[i].pv,
           tbl[i].xr, tbl[i].xe, 1'b1);
      wait_rsp();
    end

    // Reset in the middle of a write frame at bit 40
    send(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (mon_bit == 40) begin ok = 1'b1; break; end
    end
    chk("abort_reached_bit40", 64'(ok), 64'd1);
    @(posedge CLK); #1;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, MDC, MDIO_O, MDIO_OE},
        {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    n0 = rsp_cnt;
    @(posedge CLK); #1;
    rst = 1'b1;
    repeat (600) @(posedge CLK);
    #1;
    chk("abort_no_rsp", 64'(rsp_cnt), 64'(n0));
    send(1'b1, 5'd2, 5'd4, 16'h00FF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    wait_rsp();

    // Back-to-back writes with cmd_valid held
    phy_present = 1'b0;
    cmd_write = 1'b1; cmd_phy = 5'd3; cmd_reg = 5'd4; cmd_wdata = 16'hBEEF;
    cmd_valid = 1'b1;
    push_exp(1'b1, 5'd3, 5'd4, 16'hBEEF, 16'h0, 1'b0);
    wait_accept();
    cmd_phy = 5'd5; cmd_reg = 5'd6; cmd_wdata = 16'h0F0F;
    push_exp(1'b1, 5'd5, 5'd6, 16'h0F0F, 16'h0, 1'b0);
    ok = 1'b0;
    rc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (rsp_valid) begin ok = 1'b1; rc = cyc; break; end
    end
    chk("b2b_first_rsp", 64'(ok), 64'd1);
    @(negedge CLK); #1;
    chk("b2b_ready_after_rsp", 64'(cmd_ready), 64'd1);
    @(posedge CLK); #1;
    chk("b2b_accept_cycle", 64'(acc_cyc), 64'(rc + 1));
    cmd_valid = 1'b0;
    cmd_wdata = 16'h1234;
    wait_rsp();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
